// File: rtl/lzrw1_copy_controller.sv
// LZRW1 decompressor back end: turns literal/copy tokens into a byte stream,
// writing every emitted byte into the history buffer and replaying copies from it.
module lzrw1_copy_controller #(
  parameter int HISTORY_SIZE = 4096,
  parameter int LEN_WIDTH    = 5,
  localparam int ADDR_WIDTH  = $clog2(HISTORY_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_is_match,
  input  logic [7:0]            in_literal,
  input  logic [ADDR_WIDTH-1:0] in_offset,
  input  logic [LEN_WIDTH-1:0]  in_length,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  output logic                  hist_wr_en,
  output logic [ADDR_WIDTH-1:0] hist_wr_addr,
  output logic [7:0]            hist_wr_data,
  output logic [ADDR_WIDTH-1:0] hist_rd_addr,
  input  logic [7:0]            hist_rd_data,
  output logic                  busy,
  output logic                  err_offset
);

  typedef enum logic {IDLE = 1'b0, COPY = 1'b1} state_t;

  localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(HISTORY_SIZE);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  err_q, err_d;

  logic emit;
  logic accept;
  logic match_legal;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
    end
  end

  // A copy may only reach back over bytes that have actually been produced.
  assign match_legal = (in_offset != '0) && ({1'b0, in_offset} <= fill_q) &&
                       (in_length != '0);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    err_d       = err_q;

    if (emit) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + (ADDR_WIDTH+1)'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (accept && in_is_match) begin
          if (match_legal) begin
            state_d     = COPY;
            offset_d    = in_offset;
            remaining_d = in_length;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COPY: begin
        if (emit) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshakes are suppressed while reset is high so an abandoned copy writes nothing.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (in_is_match) begin
            in_ready = 1'b1;
          end else begin
            out_valid = in_valid;
            in_ready  = out_ready;
          end
        end
        COPY: begin
          out_valid = 1'b1;
          busy      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_data     = (state_q == COPY) ? hist_rd_data : in_literal;
  assign accept       = in_valid & in_ready;
  assign emit         = out_valid & out_ready;
  assign hist_wr_en   = emit;
  assign hist_wr_addr = wr_ptr_q;
  assign hist_wr_data = out_data;
  assign hist_rd_addr = wr_ptr_q - offset_q;
  assign err_offset   = err_q;

endmodule

// File: tb/tb_lzrw1_copy_controller.sv
// Bench for lzrw1_copy_controller: models the history RAM and predicts the byte
// stream from the token sequence using a flat list of all bytes produced so far.
module tb_lzrw1_copy_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_is_match;
  logic [7:0]  in_literal;
  logic [11:0] in_offset;
  logic [4:0]  in_length;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        hist_wr_en;
  logic [11:0] hist_wr_addr;
  logic [7:0]  hist_wr_data;
  logic [11:0] hist_rd_addr;
  logic [7:0]  hist_rd_data;
  logic        busy;
  logic        err_offset;

  lzrw1_copy_controller dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_is_match  (in_is_match),
    .in_literal   (in_literal),
    .in_offset    (in_offset),
    .in_length    (in_length),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .hist_wr_en   (hist_wr_en),
    .hist_wr_addr (hist_wr_addr),
    .hist_wr_data (hist_wr_data),
    .hist_rd_addr (hist_rd_addr),
    .hist_rd_data (hist_rd_data),
    .busy         (busy),
    .err_offset   (err_offset)
  );

  always #5 clock = ~clock;

  // History RAM: registered write, combinational read.
  logic [7:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  always @(posedge clock) if (hist_wr_en) mem[hist_wr_addr] <= hist_wr_data;
  assign hist_rd_data = mem[hist_rd_addr];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wr_count = 0;
  logic [11:0] last_wr_addr = '0;
  bit rand_rdy = 0;

  // Reference model: every byte ever produced since reset, plus pending expectations.
  logic [7:0]  model_stream [$];
  logic [7:0]  exp_data [$];
  logic [11:0] exp_addr [$];
  bit          model_err = 0;

  always @(posedge clock) cyc++;

  function automatic void model_push(input logic [7:0] b);
    exp_addr.push_back(12'(model_stream.size()));
    exp_data.push_back(b);
    model_stream.push_back(b);
  endfunction

  function automatic void model_match(input int off, input int len);
    int fill;
    fill = (model_stream.size() > 4096) ? 4096 : model_stream.size();
    if (off == 0 || off > fill || len == 0) begin
      model_err = 1;
    end else begin
      for (int i = 0; i < len; i++) model_push(model_stream[model_stream.size() - off]);
    end
  endfunction

  function automatic void model_clear();
    model_stream.delete();
    exp_data.delete();
    exp_addr.delete();
    model_err = 0;
  endfunction

  // Scoreboard: each history write must be the next predicted byte at the predicted address.
  logic [7:0]  sb_d;
  logic [11:0] sb_a;
  always @(negedge clock) begin
    if (hist_wr_en === 1'b1) begin
      wr_count++;
      last_wr_addr = hist_wr_addr;
      vectors++;
      if (exp_data.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr=%0d data=%h, no byte expected", hist_wr_addr, hist_wr_data);
      end else begin
        sb_d = exp_data.pop_front();
        sb_a = exp_addr.pop_front();
        if (hist_wr_addr !== sb_a || hist_wr_data !== sb_d || out_data !== sb_d ||
            out_valid !== 1'b1 || out_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL emit_byte: got addr=%0d wr=%h out=%h ov=%b, want addr=%0d data=%h",
                   hist_wr_addr, hist_wr_data, out_data, out_valid, sb_a, sb_d);
        end
      end
    end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL emit_without_write: out_data=%h hist_wr_en=%b, want hist_wr_en=1", out_data, hist_wr_en);
    end
  end

  task automatic idle_inputs();
    in_valid = 0; in_is_match = 0; in_literal = 0; in_offset = 0; in_length = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    model_clear();
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic put_token(input bit m, input logic [7:0] lit, input int off, input int len);
    int n = 0;
    bit done = 0;
    in_valid = 1; in_is_match = m; in_literal = lit;
    in_offset = 12'(off); in_length = 5'(len);
    while (!done && n < 400) begin
      @(negedge clock);
      done = (in_ready === 1'b1);
      @(posedge clock); #1;
      n++;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    idle_inputs();
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL token_accept_timeout: in_ready never 1 in %0d cycles, want 1", n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    bit done = 0;
    while (!done && n < 400) begin
      @(negedge clock);
      done = (busy === 1'b0);
      if (!done) begin
        @(posedge clock); #1;
        n++;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic test_reset();
    out_ready = 1;
    do_reset();
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0 || hist_wr_en !== 1'b0 || busy !== 1'b0 || err_offset !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ov=%b we=%b busy=%b err=%b, want 0 0 0 0",
               out_valid, hist_wr_en, busy, err_offset);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: in_ready=%b, want 1", in_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_literals();
    int c0 = cyc;
    int w0 = wr_count;
    foreach (model_stream[i]) ;
    for (int i = 0; i < 3; i++) begin
      model_push(8'h41 + 8'(i));
      put_token(0, 8'h41 + 8'(i), 0, 0);
    end
    vectors++;
    if (cyc - c0 !== 3 || wr_count - w0 !== 3) begin
      miscompares++;
      $display("FAIL literal_rate: cycles=%0d writes=%0d, want 3 3", cyc - c0, wr_count - w0);
    end
  endtask

  task automatic test_copy();
    int n = 0;
    bit done = 0;
    model_match(3, 6);
    put_token(1, 8'h00, 3, 6);
    while (!done && n < 50) begin
      @(negedge clock);
      if (busy === 1'b1) n++; else done = 1;
      if (!done) begin @(posedge clock); #1; end
    end
    vectors++;
    if (n !== 6) begin
      miscompares++;
      $display("FAIL copy_busy_cycles: busy cycles=%0d, want 6", n);
    end
    vectors++;
    if (exp_data.size() !== 0) begin
      miscompares++;
      $display("FAIL copy_bytes: %0d bytes outstanding, want 0", exp_data.size());
    end
    @(posedge clock); #1;
    model_push(8'h99);
    put_token(0, 8'h99, 0, 0);
    @(negedge clock);
    vectors++;
    if (last_wr_addr !== 12'd9) begin
      miscompares++;
      $display("FAIL copy_wr_ptr: next literal addr=%0d, want 9", last_wr_addr);
    end
  endtask

  task automatic test_rle();
    do_reset();
    model_push(8'h5A);
    put_token(0, 8'h5A, 0, 0);
    model_match(1, 5);
    put_token(1, 8'h00, 1, 5);
    wait_idle();
    for (int i = 1; i <= 5; i++) begin
      vectors++;
      if (mem[i] !== 8'h5A) begin
        miscompares++;
        $display("FAIL rle_history: mem[%0d]=%h, want 5a", i, mem[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int w0;
    logic [7:0] abc [3];
    abc[0] = 8'h41; abc[1] = 8'h42; abc[2] = 8'h43;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 3; i++) begin model_push(abc[i]); put_token(0, abc[i], 0, 0); end
      w0 = wr_count;
      model_match(pass == 0 ? 0 : 5, pass == 0 ? 4 : 2);
      put_token(1, 8'h00, pass == 0 ? 0 : 5, pass == 0 ? 4 : 2);
      @(negedge clock);
      vectors++;
      if (err_offset !== 1'b1 || busy !== 1'b0 || wr_count !== w0) begin
        miscompares++;
        $display("FAIL illegal_match%0d: err=%b busy=%b writes=%0d, want 1 0 0",
                 pass, err_offset, busy, wr_count - w0);
      end
      @(posedge clock); #1;
    end
    // fill is 3 here: offset 3 is still legal and must replay 'A'.
    model_match(3, 1);
    put_token(1, 8'h00, 3, 1);
    wait_idle();
    @(posedge clock); #1;
    model_push(8'h44);
    w0 = wr_count;
    put_token(0, 8'h44, 0, 0);
    @(negedge clock);
    vectors++;
    if (wr_count - w0 !== 1 || err_offset !== 1'b1 || exp_data.size() !== 0) begin
      miscompares++;
      $display("FAIL after_error: writes=%0d err=%b pending=%0d, want 1 1 0",
               wr_count - w0, err_offset, exp_data.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure();
    int w0;
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      model_push(b);
      put_token(0, b, 0, 0);
    end
    w0 = wr_count;
    model_match(4, 6);
    put_token(1, 8'h00, 4, 6);
    @(posedge clock); #1;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (hist_wr_en !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1 || out_data !== exp_data[0]) begin
        miscompares++;
        $display("FAIL stall_hold%0d: we=%b ov=%b busy=%b data=%h, want 0 1 1 %h",
                 i, hist_wr_en, out_valid, busy, out_data, exp_data[0]);
      end
      @(posedge clock); #1;
    end
    out_ready = 1;
    wait_idle();
    vectors++;
    if (wr_count - w0 !== 6 || exp_data.size() !== 0) begin
      miscompares++;
      $display("FAIL stall_total: writes=%0d pending=%0d, want 6 0", wr_count - w0, exp_data.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_midcopy();
    do_reset();
    for (int i = 0; i < 4; i++) begin model_push(8'hC0 + 8'(i)); put_token(0, 8'hC0 + 8'(i), 0, 0); end
    model_match(2, 6);
    put_token(1, 8'h00, 2, 6);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1;
    model_clear();
    @(negedge clock);
    vectors++;
    if (hist_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abandon_write: we=%b during reset, want 0", hist_wr_en);
    end
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midcopy_idle: ov=%b busy=%b, want 0 0", out_valid, busy);
    end
    @(posedge clock); #1;
    model_push(8'h77);
    put_token(0, 8'h77, 0, 0);
    @(negedge clock);
    vectors++;
    if (last_wr_addr !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_wr_ptr: addr=%0d, want 0", last_wr_addr);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    logic [7:0] want [6];
    logic [11:0] addrs [6];
    do_reset();
    for (int i = 0; i < 4094; i++) begin
      b = 8'($urandom);
      model_push(b);
      put_token(0, b, 0, 0);
    end
    model_push(8'h11); put_token(0, 8'h11, 0, 0);
    model_push(8'h22); put_token(0, 8'h22, 0, 0);
    model_match(2, 4);
    put_token(1, 8'h00, 2, 4);
    wait_idle();
    addrs[0] = 12'd4094; addrs[1] = 12'd4095;
    for (int i = 2; i < 6; i++) addrs[i] = 12'(i - 2);
    for (int i = 0; i < 6; i++) want[i] = (i % 2 == 0) ? 8'h11 : 8'h22;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (mem[addrs[i]] !== want[i]) begin
        miscompares++;
        $display("FAIL wrap_history: mem[%0d]=%h, want %h", addrs[i], mem[addrs[i]], want[i]);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int off, len, lim;
    logic [7:0] b;
    do_reset();
    rand_rdy = 1;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 9) < 6 || model_stream.size() == 0) begin
        b = 8'($urandom);
        model_push(b);
        put_token(0, b, 0, 0);
      end else begin
        lim = model_stream.size() + 2;
        if (lim > 4095) lim = 4095;
        off = $urandom_range(0, lim);
        len = $urandom_range(0, 31);
        model_match(off, len);
        put_token(1, 8'h00, off, len);
      end
    end
    rand_rdy = 0;
    out_ready = 1;
    wait_idle();
    @(negedge clock);
    vectors++;
    if (exp_data.size() !== 0 || err_offset !== model_err) begin
      miscompares++;
      $display("FAIL random_end: pending=%0d err=%b, want 0 %b", exp_data.size(), err_offset, model_err);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    idle_inputs();
    out_ready = 1;
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_literals();
    test_copy();
    test_rle();
    test_illegal();
    test_backpressure();
    test_reset_midcopy();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
